// File: rtl/irq_seq_pkg.sv
// Shared types and helpers for the interrupt sequencer: FSM state encoding,
// grant index width and a one-hot to index converter.
package irq_seq_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned MAX_CH = 16;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StOffer  = 2'd1,
        StRetire = 2'd2
    } state_e;

    // Input must be one-hot or zero; zero maps to index 0.
    function automatic logic [ID_W-1:0] onehot_to_idx(input logic [MAX_CH-1:0] onehot);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (onehot[i]) begin
                idx = idx | ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_prio_pick.sv
// Combinational picker: first set bit of the eligible vector, searching upward
// from start_i and wrapping past N_CH-1 back to 0.
module irq_prio_pick
    import irq_seq_pkg::*;
#(
    parameter int unsigned N_CH = 9
) (
    input  logic [N_CH-1:0] eligible_i,
    input  logic [ID_W-1:0] start_i,
    output logic            any_o,
    output logic [ID_W-1:0] index_o,
    output logic [N_CH-1:0] onehot_o
);

    logic          found;
    logic [ID_W:0] sum;
    logic [ID_W-1:0] pos;

    always_comb begin
        onehot_o = '0;
        found    = 1'b0;
        sum      = '0;
        pos      = '0;
        for (int k = 0; k < N_CH; k++) begin
            sum = {1'b0, start_i} + (ID_W + 1)'(k);
            if (sum >= (ID_W + 1)'(N_CH)) begin
                sum = sum - (ID_W + 1)'(N_CH);
            end
            pos = sum[ID_W-1:0];
            if (!found && eligible_i[pos]) begin
                onehot_o[pos] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    assign any_o   = found;
    assign index_o = onehot_to_idx(MAX_CH'(onehot_o));

endmodule

// File: rtl/irq_seq_ctrl.sv
// Interrupt request front-end: edge capture, pending/mask registers, overrun
// counter and a valid/ready grant FSM. Define IRQ_SEQ_RR_EN for round-robin.
module irq_seq_ctrl
    import irq_seq_pkg::*;
#(
    parameter int unsigned N_CH  = 9,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  req_i,
    input  logic             mask_we_i,
    input  logic [N_CH-1:0]  mask_i,
    input  logic             grant_ready_i,
    output logic             grant_valid_o,
    output logic [ID_W-1:0]  grant_id_o,
    output logic [N_CH-1:0]  grant_onehot_o,
    output logic [N_CH-1:0]  pending_o,
    output logic [N_CH-1:0]  mask_o,
    output logic [CNT_W-1:0] overrun_cnt_o,
    output logic             busy_o
);

    state_e state_q, state_d;

    logic [N_CH-1:0]  req_q;
    logic [N_CH-1:0]  pending_q, pending_d;
    logic [N_CH-1:0]  mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [N_CH-1:0]  onehot_q, onehot_d;

    logic [N_CH-1:0]  rise;
    logic [N_CH-1:0]  retire_vec;
    logic [N_CH-1:0]  eligible;
    logic             accept;
    logic             overrun;
    logic [ID_W-1:0]  start;
    logic             pick_any;
    logic [ID_W-1:0]  pick_idx;
    logic [N_CH-1:0]  pick_onehot;

    assign rise       = req_i & ~req_q;
    assign accept     = valid_q & grant_ready_i;
    assign retire_vec = accept ? onehot_q : '0;
    assign eligible   = pending_q & mask_q;
    // A rise on a channel being retired this cycle re-arms it rather than overrunning.
    assign overrun    = |(rise & pending_q & ~retire_vec);

    always_comb begin
        pending_d = (pending_q & ~retire_vec) | rise;
        mask_d    = mask_we_i ? mask_i : mask_q;
        cnt_d     = cnt_q;
        if (overrun && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

`ifdef IRQ_SEQ_RR_EN
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (id_q == ID_W'(N_CH - 1)) ? '0 : id_q + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign start = rr_ptr_q;
`else
    assign start = '0;
`endif

    irq_prio_pick #(
        .N_CH (N_CH)
    ) u_pick (
        .eligible_i (eligible),
        .start_i    (start),
        .any_o      (pick_any),
        .index_o    (pick_idx),
        .onehot_o   (pick_onehot)
    );

    // Offer fields are only loaded in IDLE, so a mask change cannot withdraw an offer.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        id_d     = id_q;
        onehot_d = onehot_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    valid_d  = 1'b1;
                    id_d     = pick_idx;
                    onehot_d = pick_onehot;
                    state_d  = StOffer;
                end
            end
            StOffer: begin
                if (accept) begin
                    valid_d  = 1'b0;
                    onehot_d = '0;
                    state_d  = StRetire;
                end
            end
            StRetire: begin
                state_d = StIdle;
            end
            default: begin
                state_d  = StIdle;
                valid_d  = 1'b0;
                onehot_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            req_q     <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            onehot_q  <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_i;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            onehot_q  <= onehot_d;
        end
    end

    assign grant_valid_o  = valid_q;
    assign grant_id_o     = id_q;
    assign grant_onehot_o = onehot_q;
    assign pending_o      = pending_q;
    assign mask_o         = mask_q;
    assign overrun_cnt_o  = cnt_q;
    assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_irq_seq_ctrl.sv
// Self-checking bench for irq_seq_ctrl: scoreboard of expected grant ids,
// with round-robin expectations when IRQ_SEQ_RR_EN is defined.
module tb_irq_seq_ctrl;

    localparam int unsigned N_CH  = 9;
    localparam int unsigned CNT_W = 8;
`ifdef IRQ_SEQ_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_CH-1:0]  req_i;
    logic             mask_we_i;
    logic [N_CH-1:0]  mask_i;
    logic             grant_ready_i;
    logic             grant_valid_o;
    logic [3:0]       grant_id_o;
    logic [N_CH-1:0]  grant_onehot_o;
    logic [N_CH-1:0]  pending_o;
    logic [N_CH-1:0]  mask_o;
    logic [CNT_W-1:0] overrun_cnt_o;
    logic             busy_o;

    int          compared   = 0;
    int          mismatched = 0;
    int unsigned exp_q[$];
    int unsigned rr_exp     = 0;
    int unsigned exp_cnt    = 0;

    irq_seq_ctrl #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req_i),
        .mask_we_i      (mask_we_i),
        .mask_i         (mask_i),
        .grant_ready_i  (grant_ready_i),
        .grant_valid_o  (grant_valid_o),
        .grant_id_o     (grant_id_o),
        .grant_onehot_o (grant_onehot_o),
        .pending_o      (pending_o),
        .mask_o         (mask_o),
        .overrun_cnt_o  (overrun_cnt_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N_CH-1:0] oh_of(input int unsigned e);
        return N_CH'(1) << e;
    endfunction

    task automatic wait_valid(output bit ok, output int n);
        n = 0;
        while (grant_valid_o !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        ok = (grant_valid_o === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_i = '0; mask_we_i = 1'b0; mask_i = '0; grant_ready_i = 1'b0;
        step();
        step();
        #3 rst_n = 1'b1;
        step();
        compared++;
        if ({grant_valid_o, grant_id_o, grant_onehot_o, pending_o, busy_o} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: valid=%b id=%0d oh=%h pend=%h busy=%b, want all 0",
                     grant_valid_o, grant_id_o, grant_onehot_o, pending_o, busy_o);
        end
        compared++;
        if (mask_o !== 9'h1FF || overrun_cnt_o !== 8'd0) begin
            mismatched++;
            $display("FAIL reset_mask_cnt: mask=%h cnt=%0d, want mask=1ff cnt=0",
                     mask_o, overrun_cnt_o);
        end
    endtask

    task automatic test_single();
        bit ok; int n; int unsigned e;
        exp_q.push_back(5);
        req_i = 9'h020;
        step();
        req_i = '0;
        compared++;
        if (pending_o !== 9'h020 || grant_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL single_pending: pend=%h valid=%b, want pend=020 valid=0",
                     pending_o, grant_valid_o);
        end
        step();
        e = exp_q.pop_front();
        compared++;
        if ({grant_valid_o, grant_id_o, grant_onehot_o, busy_o} !== {1'b1, 4'(e), oh_of(e), 1'b1})
        begin
            mismatched++;
            $display("FAIL single_offer: valid=%b id=%0d oh=%h busy=%b, want 1 %0d %h 1",
                     grant_valid_o, grant_id_o, grant_onehot_o, busy_o, e, oh_of(e));
        end
        rr_exp = (e + 1) % N_CH;
        grant_ready_i = 1'b1;
        step();
        grant_ready_i = 1'b0;
        compared++;
        if ({pending_o, grant_valid_o, grant_onehot_o, busy_o} !== {9'h000, 1'b0, 9'h000, 1'b1})
        begin
            mismatched++;
            $display("FAIL single_retire: pend=%h valid=%b oh=%h busy=%b, want 000 0 000 1",
                     pending_o, grant_valid_o, grant_onehot_o, busy_o);
        end
        step();
        compared++;
        if (busy_o !== 1'b0) begin
            mismatched++;
            $display("FAIL single_idle: busy=%b, want 0", busy_o);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned start, e;
        int n;
        start = RR ? rr_exp : 0;
        for (int i = 0; i < N_CH; i++) exp_q.push_back((start + i) % N_CH);
        grant_ready_i = 1'b1;
        req_i = 9'h1FF;
        for (int g = 0; g < N_CH; g++) begin
            n = 0;
            do begin
                step();
                req_i = '0;
                n++;
            end while (grant_valid_o !== 1'b1 && n < 10);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 99;
            compared++;
            if (grant_valid_o !== 1'b1 || grant_id_o !== 4'(e) || grant_onehot_o !== oh_of(e)
                || n != ((g == 0) ? 2 : 3)) begin
                mismatched++;
                $display("FAIL b2b_grant%0d: valid=%b id=%0d oh=%h gap=%0d, want 1 %0d %h %0d",
                         g, grant_valid_o, grant_id_o, grant_onehot_o, n, e, oh_of(e),
                         (g == 0) ? 2 : 3);
            end
            rr_exp = (e + 1) % N_CH;
        end
        step();
        step();
        grant_ready_i = 1'b0;
        compared++;
        if (pending_o !== 9'h000 || busy_o !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_drain: pend=%h busy=%b, want 000 0", pending_o, busy_o);
        end
    endtask

    task automatic test_mask();
        bit ok; int n; int unsigned e;
        mask_we_i = 1'b1; mask_i = 9'h1F7;
        step();
        mask_we_i = 1'b0;
        req_i = 9'h008;
        step();
        req_i = '0;
        step(); step(); step();
        compared++;
        if ({grant_valid_o, busy_o, pending_o, mask_o} !== {1'b0, 1'b0, 9'h008, 9'h1F7}) begin
            mismatched++;
            $display("FAIL mask_block: valid=%b busy=%b pend=%h mask=%h, want 0 0 008 1f7",
                     grant_valid_o, busy_o, pending_o, mask_o);
        end
        exp_q.push_back(3);
        mask_we_i = 1'b1; mask_i = 9'h1FF;
        step();
        mask_we_i = 1'b0;
        compared++;
        if (grant_valid_o !== 1'b0 || mask_o !== 9'h1FF) begin
            mismatched++;
            $display("FAIL mask_load: valid=%b mask=%h, want 0 1ff", grant_valid_o, mask_o);
        end
        step();
        e = exp_q.pop_front();
        compared++;
        if (grant_valid_o !== 1'b1 || grant_id_o !== 4'(e) || grant_onehot_o !== oh_of(e)) begin
            mismatched++;
            $display("FAIL mask_unblock: valid=%b id=%0d oh=%h, want 1 %0d %h",
                     grant_valid_o, grant_id_o, grant_onehot_o, e, oh_of(e));
        end
        rr_exp = (e + 1) % N_CH;
        grant_ready_i = 1'b1;
        step();
        grant_ready_i = 1'b0;
        step();
    endtask

    task automatic test_mask_during_offer();
        bit ok; int n; int unsigned e;
        exp_q.push_back(2);
        req_i = 9'h004;
        step();
        req_i = '0;
        wait_valid(ok, n);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 99;
        compared++;
        if (!ok || grant_id_o !== 4'(e)) begin
            mismatched++;
            $display("FAIL mo_offer: valid=%b id=%0d, want 1 %0d", grant_valid_o, grant_id_o, e);
        end
        rr_exp = (e + 1) % N_CH;
        mask_we_i = 1'b1; mask_i = 9'h000; req_i = 9'h010;
        step();
        mask_we_i = 1'b0; req_i = '0;
        step(); step();
        compared++;
        if ({mask_o, grant_valid_o, grant_id_o, grant_onehot_o} !== {9'h000, 1'b1, 4'd2, 9'h004})
        begin
            mismatched++;
            $display("FAIL mo_hold: mask=%h valid=%b id=%0d oh=%h, want 000 1 2 004",
                     mask_o, grant_valid_o, grant_id_o, grant_onehot_o);
        end
        grant_ready_i = 1'b1;
        step();
        grant_ready_i = 1'b0;
        step(); step(); step(); step();
        compared++;
        if ({grant_valid_o, busy_o, pending_o} !== {1'b0, 1'b0, 9'h010}) begin
            mismatched++;
            $display("FAIL mo_nogrant: valid=%b busy=%b pend=%h, want 0 0 010",
                     grant_valid_o, busy_o, pending_o);
        end
        exp_q.push_back(4);
        mask_we_i = 1'b1; mask_i = 9'h1FF;
        step();
        mask_we_i = 1'b0;
        wait_valid(ok, n);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 99;
        compared++;
        if (!ok || grant_id_o !== 4'(e) || grant_onehot_o !== oh_of(e)) begin
            mismatched++;
            $display("FAIL mo_release: valid=%b id=%0d oh=%h, want 1 %0d %h",
                     grant_valid_o, grant_id_o, grant_onehot_o, e, oh_of(e));
        end
        rr_exp = (e + 1) % N_CH;
        grant_ready_i = 1'b1;
        step();
        grant_ready_i = 1'b0;
        step();
    endtask

    task automatic test_overrun();
        bit ok; int n; int unsigned e;
        grant_ready_i = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            req_i = 9'h080;
            step();
            req_i = '0;
            step();
            if (i > 0) exp_cnt++;
        end
        compared++;
        if (overrun_cnt_o !== 8'(exp_cnt)) begin
            mismatched++;
            $display("FAIL ovr_three_rises: cnt=%0d, want %0d", overrun_cnt_o, exp_cnt);
        end
        // First pulse sets channel 6 fresh; second overruns both 6 and 7 at once.
        for (int i = 0; i < 2; i++) begin
            req_i = 9'h0C0;
            step();
            req_i = '0;
            step();
            exp_cnt++;
        end
        compared++;
        if (overrun_cnt_o !== 8'(exp_cnt)) begin
            mismatched++;
            $display("FAIL ovr_multi: cnt=%0d, want %0d", overrun_cnt_o, exp_cnt);
        end
        exp_q.push_back(7);
        exp_q.push_back(6);
        for (int g = 0; g < 2; g++) begin
            wait_valid(ok, n);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 99;
            compared++;
            if (!ok || grant_id_o !== 4'(e)) begin
                mismatched++;
                $display("FAIL ovr_drain%0d: valid=%b id=%0d, want 1 %0d",
                         g, grant_valid_o, grant_id_o, e);
            end
            rr_exp = (e + 1) % N_CH;
            grant_ready_i = 1'b1;
            step();
            grant_ready_i = 1'b0;
        end
        step(); step();
        compared++;
        if (pending_o !== 9'h000 || busy_o !== 1'b0) begin
            mismatched++;
            $display("FAIL ovr_drained: pend=%h busy=%b, want 000 0", pending_o, busy_o);
        end
        req_i = 9'h080;
        step();
        req_i = '0;
        step();
        for (int i = 0; i < 300; i++) begin
            req_i = 9'h080;
            step();
            req_i = '0;
            step();
            if (exp_cnt < 255) exp_cnt++;
            if (i == 249 || i == 250 || i == 299) begin
                compared++;
                if (overrun_cnt_o !== 8'(exp_cnt)) begin
                    mismatched++;
                    $display("FAIL ovr_sat_%0d: cnt=%0d, want %0d", i, overrun_cnt_o, exp_cnt);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        compared++;
        if (grant_valid_o !== 1'b1 || grant_id_o !== 4'd7) begin
            mismatched++;
            $display("FAIL rst_pre_offer: valid=%b id=%0d, want 1 7", grant_valid_o, grant_id_o);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if ({grant_valid_o, grant_id_o, grant_onehot_o, pending_o, busy_o, overrun_cnt_o}
            !== '0 || mask_o !== 9'h1FF) begin
            mismatched++;
            $display("FAIL rst_async: valid=%b id=%0d oh=%h pend=%h busy=%b cnt=%0d mask=%h",
                     grant_valid_o, grant_id_o, grant_onehot_o, pending_o, busy_o,
                     overrun_cnt_o, mask_o);
        end
        #2 rst_n = 1'b1;
        step(); step(); step();
        compared++;
        if (grant_valid_o !== 1'b0 || busy_o !== 1'b0 || pending_o !== 9'h000) begin
            mismatched++;
            $display("FAIL rst_after: valid=%b busy=%b pend=%h, want 0 0 000",
                     grant_valid_o, busy_o, pending_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mask();
        test_mask_during_offer();
        test_overrun();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
